// File: rtl/unsigned_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the default operand width.
package unsigned_divider_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/unsigned_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake. Divide-by-zero skips the iteration loop.
module unsigned_divider
    import unsigned_divider_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         sclk,
    input  logic         s_rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  dq;
    logic [W-1:0]  dvs;
    logic [W-1:0]  rem;
    logic [CW-1:0] cnt;

    logic [W:0]    t;
    logic          qbit;
    logic [W-1:0]  new_rem;
    logic [W-1:0]  new_dq;

    // The restored remainder is always below dvs, so its top bit is zero and
    // W bits suffice; subtracting on the low W bits gives the same result.
    always_comb begin
        t       = {rem, dq[W-1]};
        qbit    = (t >= {1'b0, dvs});
        new_rem = qbit ? (t[W-1:0] - dvs) : t[W-1:0];
        new_dq  = {dq[W-2:0], qbit};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            dq          <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        dq          <= dividend;
                        dvs         <= divisor;
                        rem         <= '0;
                        cnt         <= '0;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            done      <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    rem <= new_rem;
                    dq  <= new_dq;
                    cnt <= cnt + 1'b1;
                    // Final iteration publishes the next-state values directly.
                    if (cnt == LAST_ITER) begin
                        quotient  <= new_dq;
                        remainder <= new_rem;
                        done      <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed and randomized self-checking bench for unsigned_divider at W=8,
// with expected results computed by the bench's own reference arithmetic.
module tb_unsigned_divider;

    localparam int W = 8;

    logic         sclk = 1'b0;
    logic         s_rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int num_checks = 0;
    int num_fails  = 0;

    unsigned_divider #(.W(W)) dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 sclk = ~sclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // One start pulse, then wait for done and check result, latency and busy span.
    task automatic applyStimulus(input int dd, input int dv, input string tag);
        int exp_q, exp_r, exp_dbz, exp_lat;
        int first_done, busy_cycles;
        exp_dbz = (dv == 0) ? 1 : 0;
        exp_q   = (dv == 0) ? 255 : dd / dv;
        exp_r   = (dv == 0) ? dd : dd % dv;
        exp_lat = (dv == 0) ? 0 : W;
        dividend = W'(dd);
        divisor  = W'(dv);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = 8'hA5;
        divisor  = 8'h3C;
        first_done  = -1;
        busy_cycles = 0;
        for (int n = 0; n <= W + 4; n++) begin
            if (n > 0) tick();
            if (busy) busy_cycles++;
            if (done) begin
                first_done = n;
                break;
            end
        end
        checkOutput({tag, " latency"}, first_done, exp_lat);
        checkOutput({tag, " busy_cycles"}, busy_cycles, exp_lat + 1);
        checkOutput({tag, " quotient"}, quotient, exp_q);
        checkOutput({tag, " remainder"}, remainder, exp_r);
        checkOutput({tag, " div_by_zero"}, div_by_zero, exp_dbz);
        tick();
        checkOutput({tag, " done_pulse_end"}, done, 0);
        checkOutput({tag, " idle_after"}, busy, 0);
        checkOutput({tag, " quotient_held"}, quotient, exp_q);
    endtask

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int done_cnt;
        int dd, dv, sel, exp_q, exp_r, exp_dbz, exp_lat, first_done;
        logic [W-1:0] q_seen, r_seen;
        logic dbz_seen;

        $display("[TB] Reset phase");
        repeat (3) tick();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset quotient", quotient, 0);
        checkOutput("reset remainder", remainder, 0);
        checkOutput("reset div_by_zero", div_by_zero, 0);
        s_rst_n = 1'b1;
        tick();
        checkOutput("post_reset busy", busy, 0);

        $display("[TB] Directed vectors");
        applyStimulus(200, 7, "200/7");
        applyStimulus(255, 1, "255/1");
        applyStimulus(5, 9, "5/9");
        applyStimulus(0, 3, "0/3");
        applyStimulus(100, 0, "100/0");
        applyStimulus(9, 3, "9/3");

        $display("[TB] Start while busy");
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        done_cnt = 0;
        for (int n = 1; n <= W + 4; n++) begin
            tick();
            if (n == 3) begin
                dividend = 8'd50;
                divisor  = 8'd5;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) done_cnt++;
        end
        checkOutput("ignored_start done_count", done_cnt, 1);
        checkOutput("ignored_start quotient", quotient, 28);
        checkOutput("ignored_start remainder", remainder, 4);
        checkOutput("ignored_start idle", busy, 0);

        $display("[TB] Reset mid-operation");
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        s_rst_n = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset quotient", quotient, 0);
        checkOutput("midreset remainder", remainder, 0);
        checkOutput("midreset div_by_zero", div_by_zero, 0);
        done_cnt = 0;
        repeat (2) begin
            tick();
            if (done) done_cnt++;
        end
        s_rst_n = 1'b1;
        repeat (W + 2) begin
            tick();
            if (done) done_cnt++;
        end
        checkOutput("midreset no_done", done_cnt, 0);
        checkOutput("midreset idle", busy, 0);
        applyStimulus(81, 9, "81/9");

        $display("[TB] Back-to-back randomized run");
        start = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            dd  = $urandom_range(255, 0);
            sel = $urandom_range(9, 0);
            if (sel == 0) dv = 0;
            else if (sel == 1 && dd < 255) dv = $urandom_range(255, dd + 1);
            else dv = $urandom_range(255, 1);
            exp_dbz = (dv == 0) ? 1 : 0;
            exp_q   = (dv == 0) ? 255 : dd / dv;
            exp_r   = (dv == 0) ? dd : dd % dv;
            exp_lat = (dv == 0) ? 0 : W;
            dividend = W'(dd);
            divisor  = W'(dv);
            first_done = -1;
            done_cnt   = 0;
            q_seen     = '0;
            r_seen     = '0;
            dbz_seen   = 1'b0;
            for (int n = 0; n <= exp_lat + 1; n++) begin
                tick();
                if (n == 0) begin
                    dividend = ~W'(dd);
                    divisor  = W'(dv + 3);
                end
                if (done) begin
                    done_cnt++;
                    if (first_done < 0) begin
                        first_done = n;
                        q_seen     = quotient;
                        r_seen     = remainder;
                        dbz_seen   = div_by_zero;
                    end
                end
            end
            checkOutput($sformatf("rand%0d %0d/%0d done_at", k, dd, dv), first_done, exp_lat);
            checkOutput($sformatf("rand%0d %0d/%0d done_count", k, dd, dv), done_cnt, 1);
            checkOutput($sformatf("rand%0d %0d/%0d quotient", k, dd, dv), q_seen, exp_q);
            checkOutput($sformatf("rand%0d %0d/%0d remainder", k, dd, dv), r_seen, exp_r);
            checkOutput($sformatf("rand%0d %0d/%0d div_by_zero", k, dd, dv), dbz_seen, exp_dbz);
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
